// File: rtl/fifo_rd_side.sv
// fifo_rd_side -- read-side controller of an asynchronous FIFO (rclk domain).
//
// Owns the binary/Gray read pointer and drives raddr into the FIFO memory.
// Captures the memory's combinational read data into a one-entry output
// register, which is offered downstream with a valid/ready handshake.
// The empty flag is computed from the Gray write pointer, which arrives
// already synchronized into rclk.
//
// Ports:
//   rclk       read-domain clock
//   rst        synchronous active-low reset, sampled on rising rclk
//   rq2_wptr   Gray write pointer synchronized into rclk (ADDR+1 bits)
//   rdata      combinational memory read data at raddr
//   raddr      memory read address (low ADDR bits of the binary read pointer)
//   rptr       registered Gray read pointer, to the write-side synchronizer
//   rempty     memory holds no unread word (registered)
//   out_data   output register contents
//   out_valid  out_data holds a word not yet accepted
//   out_ready  consumer accepts out_data this cycle when out_valid=1
module fifo_rd_side #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 3,
  parameter int DEPTH = 8
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic [ADDR:0]    rq2_wptr,
  input  logic [WIDTH-1:0] rdata,
  output logic [ADDR-1:0]  raddr,
  output logic [ADDR:0]    rptr,
  output logic             rempty,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // The pointer arithmetic relies on natural binary wrap of the memory index.
  if (DEPTH != (1 << ADDR)) begin : g_depth_check
    $error("fifo_rd_side: DEPTH must equal 2**ADDR");
  end

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  out_state_t    state, state_next;
  logic [ADDR:0] rbin;
  logic [ADDR:0] rbin_next;
  logic [ADDR:0] rgray_next;
  logic          pop;

  // A word moves from memory into the output register whenever memory has
  // one and the register is either vacant or being drained this same cycle.
  // rempty is registered, so this never pops on an empty memory.
  assign pop        = !rempty && (!out_valid || out_ready);
  assign rbin_next  = rbin + {{ADDR{1'b0}}, pop};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign raddr      = rbin[ADDR-1:0];

  // ---------------------------------------------------------------------
  // Output-stage FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge rclk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!rst) state <= OUT_EMPTY;
    else      state <= state_next;
  end

  // Output-stage FSM: next state
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_next unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      OUT_EMPTY: if (!rempty)             state_next = OUT_FULL;
      OUT_FULL:  if (out_ready && rempty) state_next = OUT_EMPTY;
      default:                            state_next = OUT_EMPTY;
    endcase
  end

  // Output-stage FSM: outputs
  always_comb begin
    out_valid = (state == OUT_FULL);
  end

  // ---------------------------------------------------------------------
  // Pointers, empty flag and output data register
  // ---------------------------------------------------------------------
  always_ff @(posedge rclk) begin
    if (!rst) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      // The held word is deliberately discarded on reset.
      out_data <= '0;
    end else begin
      rbin   <= rbin_next;
      rptr   <= rgray_next;
      // Compare against the post-pop pointer so the flag rises on the same
      // edge that takes the last word. All ADDR+1 bits are compared, so a
      // full lap of the write pointer is not mistaken for empty.
      rempty <= (rgray_next == rq2_wptr);
      if (pop) out_data <= rdata;
    end
  end

endmodule
